// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port
// synchronous memory. Port 0 is instruction fetch and port 1 is load/store.
// Each accepted request runs as one 3-cycle access:
//   gnt pulse (T), memory strobe (T+1), done pulse with read data (T+2).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   pN_req/we/addr/wdata        request from port N; held stable until pN_gnt
//   pN_gnt                      one-cycle pulse, request accepted
//   pN_done                     one-cycle pulse, access complete
//   pN_rdata                    read result, valid with pN_done, held until the
//                               next pN_done (0 after a write)
//   mem_en/we/addr/wdata        memory strobe and command, driven for one cycle
//   mem_rdata                   memory read data, valid the cycle after mem_en
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // All outputs are registered, so each one becomes visible in the cycle after
  // the edge that computed it: the edge leaving IDLE raises gnt, the edge
  // leaving ACCESS raises mem_en, the edge leaving RESP raises done.
  state_t              state_r;
  logic                last_r;     // port granted most recently
  logic                id_r;       // port owning the access in flight
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                p0_gnt_r;
  logic                p1_gnt_r;
  logic                p0_done_r;
  logic                p1_done_r;
  logic                mem_en_r;
  logic                mem_we_r;
  logic [DATA_W-1:0]   p0_rdata_r;
  logic [DATA_W-1:0]   p1_rdata_r;
  logic                any_req_s;
  logic                sel_s;      // port that wins arbitration this cycle

  // Round-robin pick: a lone requester wins, on contention the other port wins.
  always_comb begin
    any_req_s = p0_req | p1_req;
    if (p0_req && p1_req) begin
      sel_s = ~last_r;
    end else if (p1_req) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Access sequencer with registered grant, strobe, completion and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_r     <= 1'b1;
      id_r       <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      p0_gnt_r   <= 1'b0;
      p1_gnt_r   <= 1'b0;
      p0_done_r  <= 1'b0;
      p1_done_r  <= 1'b0;
      mem_en_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      p0_rdata_r <= {DATA_W{1'b0}};
      p1_rdata_r <= {DATA_W{1'b0}};
    end else begin
      p0_gnt_r  <= 1'b0;
      p1_gnt_r  <= 1'b0;
      p0_done_r <= 1'b0;
      p1_done_r <= 1'b0;
      // Read data is on mem_rdata during the done cycle; keep it afterwards.
      // we_r still describes the finishing access here even if a new grant
      // lands on this same edge.
      if (p0_done_r) begin
        p0_rdata_r <= we_r ? {DATA_W{1'b0}} : mem_rdata;
      end
      if (p1_done_r) begin
        p1_rdata_r <= we_r ? {DATA_W{1'b0}} : mem_rdata;
      end
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r <= ACCESS;
            last_r  <= sel_s;
            id_r    <= sel_s;
            if (sel_s) begin
              p1_gnt_r <= 1'b1;
              we_r     <= p1_we;
              addr_r   <= p1_addr;
              wdata_r  <= p1_wdata;
            end else begin
              p0_gnt_r <= 1'b1;
              we_r     <= p0_we;
              addr_r   <= p0_addr;
              wdata_r  <= p0_wdata;
            end
          end
        end
        ACCESS: begin
          mem_en_r <= 1'b1;
          mem_we_r <= we_r;
          state_r  <= RESP;
        end
        RESP: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          if (id_r) begin
            p1_done_r <= 1'b1;
          end else begin
            p0_done_r <= 1'b1;
          end
          state_r <= IDLE;
        end
        default: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign p0_gnt    = p0_gnt_r;
  assign p1_gnt    = p1_gnt_r;
  assign p0_done   = p0_done_r;
  assign p1_done   = p1_done_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

  // The memory returns read data only in the done cycle, so that cycle shows
  // mem_rdata directly; the register holds it from the next cycle on.
  assign p0_rdata = p0_done_r ? (we_r ? {DATA_W{1'b0}} : mem_rdata) : p0_rdata_r;
  assign p1_rdata = p1_done_r ? (we_r ? {DATA_W{1'b0}} : mem_rdata) : p1_rdata_r;

endmodule
